pipe_ctrl: RTL and testbench

Central handshake controller for the five-stage pipeline (IF/ID/EX/MEM/WB). Owns the per-stage valid bits and produces allowin, ready_go and load-enable signals for the inter-stage registers, such as the MEM→WB register's ready_go input. Detects RAW hazards in ID and inserts stall bubbles. Squashes IF/ID contents on a taken branch resolved in EX, and counts stall cycles.

---
 rtl/pipe_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline handshake controller: stage valids, allowin/ready_go, RAW stalls, branch squash.
// Optional forwarding build: define FORWARD_EN (load-use stalls only); otherwise any in-flight writer stalls ID.
module pipe_ctrl #(
  parameter int RF_AW = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_wait,
  input  logic             ex_busy,
  input  logic             mem_wait,
  input  logic [RF_AW-1:0] id_rj,
  input  logic [RF_AW-1:0] id_rk,
  input  logic             id_use_rj,
  input  logic             id_use_rk,
  input  logic [RF_AW-1:0] ex_rd,
  input  logic [RF_AW-1:0] mem_rd,
  input  logic [RF_AW-1:0] wb_rd,
  input  logic             ex_rf_we,
  input  logic             mem_rf_we,
  input  logic             wb_rf_we,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  output logic             fs_valid,
  output logic             ds_valid,
  output logic             es_valid,
  output logic             ms_valid,
  output logic             ws_valid,
  output logic             ds_allowin,
  output logic             es_allowin,
  output logic             ms_allowin,
  output logic             ws_allowin,
  output logic             fs_ready_go,
  output logic             ds_ready_go,
  output logic             es_ready_go,
  output logic             ms_ready_go,
  output logic             pc_en,
  output logic             br_flush,
  output logic [CNT_W-1:0] stall_cnt
);

  // Index 0 = EX, 1 = MEM, 2 = WB
  logic [2:0]       wr_valid;
  logic [2:0]       wr_we;
  logic [2:0]       wr_match;
  logic [RF_AW-1:0] wr_rd [3];
  logic             hazard;

  assign wr_valid = {ws_valid, ms_valid, es_valid};
  assign wr_we    = {wb_rf_we, mem_rf_we, ex_rf_we};
  assign wr_rd[0] = ex_rd;
  assign wr_rd[1] = mem_rd;
  assign wr_rd[2] = wb_rd;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_match
      assign wr_match[gi] = wr_valid[gi] & wr_we[gi] & (wr_rd[gi] != '0) &
                            ((id_use_rj & (id_rj == wr_rd[gi])) |
                             (id_use_rk & (id_rk == wr_rd[gi])));
    end
  endgenerate

`ifdef FORWARD_EN
  assign hazard = ds_valid & wr_match[0] & ex_is_load;
`else
  assign hazard = ds_valid & (|wr_match);
`endif

  assign fs_ready_go = ~if_wait;
  assign ds_ready_go = ~hazard;
  assign es_ready_go = ~ex_busy;
  assign ms_ready_go = ~mem_wait;

  assign ws_allowin = 1'b1;
  assign ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin);
  assign es_allowin = ~es_valid | (es_ready_go & ms_allowin);
  assign ds_allowin = ~ds_valid | (ds_ready_go & es_allowin);

  // A taken branch only squashes the front end in the cycle it actually leaves EX.
  assign br_flush = ~rst & es_valid & es_ready_go & ms_allowin & ex_br_taken;
  assign pc_en    = fs_ready_go & ds_allowin & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      fs_valid  <= 1'b0;
      ds_valid  <= 1'b0;
      es_valid  <= 1'b0;
      ms_valid  <= 1'b0;
      ws_valid  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      fs_valid <= 1'b1;
      if (br_flush) begin
        ds_valid <= 1'b0;
      end else if (ds_allowin) begin
        ds_valid <= fs_valid & fs_ready_go;
      end
      // A stalled ID leaves a bubble behind in EX.
      if (es_allowin) begin
        es_valid <= ds_valid & ds_ready_go & ~br_flush;
      end
      if (ms_allowin) begin
        ms_valid <= es_valid & es_ready_go;
      end
      if (ws_allowin) begin
        ws_valid <= ms_valid & ms_ready_go;
      end
      if (hazard & ~br_flush & ~(&stall_cnt)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: instruction-token pipeline model, directed corner sequences,
// a hazard vector table and a randomized run.
module tb_pipe_ctrl;

  localparam int CW  = 4;
  localparam int SAT = 15;
`ifdef FORWARD_EN
  localparam int LU_STALL  = 1;
  localparam int ALU_STALL = 0;
`else
  localparam int LU_STALL  = 3;
  localparam int ALU_STALL = 2;
`endif

  logic clk, rst;
  logic if_wait, ex_busy, mem_wait;
  logic [4:0] id_rj, id_rk, ex_rd, mem_rd, wb_rd;
  logic id_use_rj, id_use_rk, ex_rf_we, mem_rf_we, wb_rf_we, ex_is_load, ex_br_taken;
  logic fs_valid, ds_valid, es_valid, ms_valid, ws_valid;
  logic ds_allowin, es_allowin, ms_allowin, ws_allowin;
  logic fs_ready_go, ds_ready_go, es_ready_go, ms_ready_go;
  logic pc_en, br_flush;
  logic [CW-1:0] stall_cnt;

  pipe_ctrl #(.RF_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .if_wait(if_wait), .ex_busy(ex_busy), .mem_wait(mem_wait),
    .id_rj(id_rj), .id_rk(id_rk), .id_use_rj(id_use_rj), .id_use_rk(id_use_rk),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_rf_we(ex_rf_we), .mem_rf_we(mem_rf_we), .wb_rf_we(wb_rf_we),
    .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .fs_valid(fs_valid), .ds_valid(ds_valid), .es_valid(es_valid), .ms_valid(ms_valid),
    .ws_valid(ws_valid), .ds_allowin(ds_allowin), .es_allowin(es_allowin),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin), .fs_ready_go(fs_ready_go),
    .ds_ready_go(ds_ready_go), .es_ready_go(es_ready_go), .ms_ready_go(ms_ready_go),
    .pc_en(pc_en), .br_flush(br_flush), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic we, ld, br, uj, uk;
    logic [4:0] rd, rj, rk;
  } instr_t;

  typedef struct packed {
    logic [4:0] rj, rk;
    logic uj, uk;
    logic [4:0] ex_rd;
    logic ex_we, ex_ld;
    logic [4:0] mem_rd;
    logic mem_we;
    logic [4:0] wb_rd;
    logic wb_we;
    logic exp_fwd, exp_nofwd;
  } vec_t;

  // Pipeline model: one instruction token per stage (0=IF .. 4=WB)
  instr_t slot [5];
  logic   mv   [5];
  int     stall_m;
  instr_t script [$];
  logic   rand_mode, rst_on_hz, rst_hit, last_flush;
  int     n_pass, n_chk;
  int     n_flush, n_dsstall, n_ms0, n_ws1, n_pc0, n_msrg0;
  vec_t   vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic instr_t mk(input logic we, input logic [4:0] rd, input logic ld,
                                input logic br, input logic uj, input logic [4:0] rj,
                                input logic uk, input logic [4:0] rk);
    instr_t t;
    t.we = we; t.rd = rd; t.ld = ld; t.br = br;
    t.uj = uj; t.rj = rj; t.uk = uk; t.rk = rk;
    return t;
  endfunction

  function automatic logic reads(input instr_t d, input logic [4:0] r);
    return (r != 5'd0) && ((d.uj && d.rj == r) || (d.uk && d.rk == r));
  endfunction

  task automatic fetch(output instr_t t);
    t = '0;
    if (script.size() != 0) begin
      t = script.pop_front();
    end else if (rand_mode) begin
      t.we = 1'($urandom);
      t.rd = 5'($urandom_range(0, 5));
      t.ld = ($urandom_range(0, 2) == 0);
      t.br = ($urandom_range(0, 7) == 0);
      t.uj = 1'($urandom);
      t.rj = 5'($urandom_range(0, 5));
      t.uk = 1'($urandom);
      t.rk = 5'($urandom_range(0, 5));
    end
  endtask

  task automatic set_idle();
    {id_rj, id_rk, id_use_rj, id_use_rk} = '0;
    {ex_rd, ex_rf_we, ex_is_load, ex_br_taken} = '0;
    {mem_rd, mem_rf_we, wb_rd, wb_rf_we} = '0;
    if_wait = 1'b0; ex_busy = 1'b0; mem_wait = 1'b0;
  endtask

  task automatic drive_from_model();
    id_rj = slot[1].rj; id_rk = slot[1].rk; id_use_rj = slot[1].uj; id_use_rk = slot[1].uk;
    ex_rd = slot[2].rd; ex_rf_we = slot[2].we; ex_is_load = slot[2].ld; ex_br_taken = slot[2].br;
    mem_rd = slot[3].rd; mem_rf_we = slot[3].we;
    wb_rd = slot[4].rd; wb_rf_we = slot[4].we;
    if (rand_mode) begin
      if (!mv[1]) begin
        id_rj = 5'($urandom_range(0, 5)); id_use_rj = 1'b1;
        id_rk = 5'($urandom_range(0, 5)); id_use_rk = 1'b1;
      end
      if (!mv[2]) begin
        ex_rd = 5'($urandom_range(1, 5)); ex_rf_we = 1'b1;
        ex_is_load = 1'($urandom); ex_br_taken = 1'($urandom);
      end
      if (!mv[3]) begin mem_rd = 5'($urandom_range(1, 5)); mem_rf_we = 1'b1; end
      if (!mv[4]) begin wb_rd = 5'($urandom_range(1, 5)); wb_rf_we = 1'b1; end
    end
  endtask

  task automatic clr_cnt();
    n_flush = 0; n_dsstall = 0; n_ms0 = 0; n_ws1 = 0; n_pc0 = 0; n_msrg0 = 0;
  endtask

  // One clock: drive from the model, compare everything, then advance the model.
  task automatic cycle();
    logic free [5];
    logic rdy [5];
    logic nv [5];
    instr_t nxt [5];
    instr_t t;
    logic hz, fl, pce;
    logic [14:0] exp_v, act_v;
    drive_from_model();
    #1;
    hz = 1'b0;
    if (mv[1]) begin
`ifdef FORWARD_EN
      hz = mv[2] && slot[2].we && slot[2].ld && reads(slot[1], slot[2].rd);
`else
      for (int s = 2; s < 5; s++)
        if (mv[s] && slot[s].we && reads(slot[1], slot[s].rd)) hz = 1'b1;
`endif
    end
    rdy[0] = !if_wait; rdy[1] = !hz; rdy[2] = !ex_busy; rdy[3] = !mem_wait; rdy[4] = 1'b1;
    free[4] = 1'b1;
    for (int k = 3; k >= 0; k--) free[k] = !mv[k] || (rdy[k] && free[k+1]);
    fl  = !rst && mv[2] && rdy[2] && free[3] && slot[2].br;
    pce = rdy[0] && free[1] && !rst;
    exp_v = {mv[0], mv[1], mv[2], mv[3], mv[4], free[1], free[2], free[3], 1'b1,
             rdy[0], rdy[1], rdy[2], rdy[3], pce, fl};
    act_v = {fs_valid, ds_valid, es_valid, ms_valid, ws_valid,
             ds_allowin, es_allowin, ms_allowin, ws_allowin,
             fs_ready_go, ds_ready_go, es_ready_go, ms_ready_go, pc_en, br_flush};
    chk("ctl_vector", 32'(act_v), 32'(exp_v));
    chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
    last_flush = br_flush;
    if (br_flush) n_flush++;
    if (ds_valid && !ds_ready_go) n_dsstall++;
    if (!ms_valid) n_ms0++;
    if (ws_valid) n_ws1++;
    if (!pc_en) n_pc0++;
    if (!ms_ready_go) n_msrg0++;
    if (rst_on_hz && ds_valid && !ds_ready_go) begin
      rst = 1'b1;
      rst_hit = 1'b1;
    end
    @(posedge clk);
    for (int s = 0; s < 5; s++) begin nv[s] = mv[s]; nxt[s] = slot[s]; end
    if (rst) begin
      for (int s = 0; s < 5; s++) nv[s] = 1'b0;
      stall_m = 0;
    end else begin
      if (hz && !fl && stall_m < SAT) stall_m++;
      nv[4] = mv[3] && rdy[3]; nxt[4] = slot[3];
      if (free[3]) begin nv[3] = mv[2] && rdy[2]; nxt[3] = slot[2]; end
      if (free[2]) begin nv[2] = mv[1] && rdy[1] && !fl; nxt[2] = slot[1]; end
      if (fl) nv[1] = 1'b0;
      else if (free[1]) begin nv[1] = mv[0] && rdy[0]; nxt[1] = slot[0]; end
      nv[0] = 1'b1;
      if (!mv[0] || fl || (free[1] && rdy[0])) begin fetch(t); nxt[0] = t; end
    end
    for (int s = 0; s < 5; s++) begin mv[s] = nv[s]; slot[s] = nxt[s]; end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic done;
    n_pass = 0; n_chk = 0; stall_m = 0;
    rand_mode = 1'b0; rst_on_hz = 1'b0; rst_hit = 1'b0; last_flush = 1'b0;
    for (int s = 0; s < 5; s++) begin mv[s] = 1'b0; slot[s] = '0; end
    vecs[0]  = '{5'd4,  5'd0, 1'b1, 1'b0, 5'd4,  1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'd0,  5'd0, 1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1};
    vecs[2]  = '{5'd4,  5'd0, 1'b1, 1'b0, 5'd6,  1'b1, 1'b1, 5'd4,  1'b1, 5'd0,  1'b0, 1'b1, 1'b0};
    vecs[3]  = '{5'd4,  5'd0, 1'b1, 1'b0, 5'd6,  1'b1, 1'b0, 5'd0,  1'b0, 5'd4,  1'b1, 1'b1, 1'b0};
    vecs[4]  = '{5'd0,  5'd7, 1'b0, 1'b1, 5'd7,  1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'd0,  5'd7, 1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1};
    vecs[6]  = '{5'd4,  5'd0, 1'b1, 1'b0, 5'd4,  1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1};
    vecs[7]  = '{5'd4,  5'd0, 1'b1, 1'b0, 5'd4,  1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0};
    vecs[8]  = '{5'd3,  5'd9, 1'b1, 1'b1, 5'd6,  1'b0, 1'b0, 5'd0,  1'b0, 5'd9,  1'b1, 1'b1, 1'b0};
    vecs[9]  = '{5'd5,  5'd5, 1'b0, 1'b0, 5'd5,  1'b1, 1'b1, 5'd5,  1'b1, 5'd5,  1'b1, 1'b1, 1'b1};
    vecs[10] = '{5'd12, 5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd12, 1'b0, 5'd13, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{5'd31, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1; set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valids", 32'({fs_valid, ds_valid, es_valid, ms_valid, ws_valid}), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(br_flush), 32'd0);

    // Free run, no waits
    rst = 1'b0; clr_cnt();
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (i == 0) chk("free_fs_valid", 32'(fs_valid), 32'd1);
      if (i == 3) chk("free_ws_early", 32'(ws_valid), 32'd0);
      if (i == 4) chk("free_ws_valid", 32'(ws_valid), 32'd1);
    end
    chk("free_pc_en_low", 32'(n_pc0), 32'd0);
    chk("free_stall", 32'(stall_cnt), 32'd0);

    // Load-use on r4
    s0 = int'(stall_cnt); clr_cnt();
    script.push_back(mk(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0));
    script.push_back(mk(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0));
    run(12);
    chk("lu_stall_delta", 32'(int'(stall_cnt) - s0), 32'(LU_STALL));
    chk("lu_ds_hold", 32'(n_dsstall), 32'(LU_STALL));
    chk("lu_ms_bubbles", 32'(n_ms0), 32'(LU_STALL));

    // Load to r0 never stalls
    s0 = int'(stall_cnt); clr_cnt();
    script.push_back(mk(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0));
    script.push_back(mk(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0));
    run(8);
    chk("r0_stall_delta", 32'(int'(stall_cnt) - s0), 32'd0);
    chk("r0_ds_hold", 32'(n_dsstall), 32'd0);

    // ALU writer to r4 in MEM when the reader is in ID
    s0 = int'(stall_cnt); clr_cnt();
    script.push_back(mk(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0));
    script.push_back(mk(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0));
    script.push_back(mk(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4));
    run(12);
    chk("alu_stall_delta", 32'(int'(stall_cnt) - s0), 32'(ALU_STALL));
    chk("alu_ds_hold", 32'(n_dsstall), 32'(ALU_STALL));

    // Taken branch
    clr_cnt(); done = 1'b0;
    script.push_back(mk(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0));
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_flush && !done) begin
        chk("br_ds_valid", 32'(ds_valid), 32'd0);
        chk("br_es_valid", 32'(es_valid), 32'd0);
        chk("br_ms_valid", 32'(ms_valid), 32'd1);
        done = 1'b1;
      end
    end
    chk("br_flush_cycles", 32'(n_flush), 32'd1);

    // MEM waits three cycles
    run(5);
    clr_cnt();
    for (int i = 0; i < 9; i++) begin
      mem_wait = (i < 3);
      cycle();
    end
    mem_wait = 1'b0;
    chk("mw_pc_en_low", 32'(n_pc0), 32'd3);
    chk("mw_ms_not_ready", 32'(n_msrg0), 32'd3);
    chk("mw_ws_valid", 32'(n_ws1), 32'd6);

    // Hazard coinciding with the branch flush
    s0 = int'(stall_cnt); clr_cnt(); done = 1'b0;
    script.push_back(mk(1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0));
    script.push_back(mk(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0));
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_flush && !done) begin
        chk("hf_ds_valid", 32'(ds_valid), 32'd0);
        done = 1'b1;
      end
    end
    chk("hf_flush_cycles", 32'(n_flush), 32'd1);
    chk("hf_stall_delta", 32'(int'(stall_cnt) - s0), 32'd0);

    // Reset asserted while ID is stalled
    rst_hit = 1'b0; rst_on_hz = 1'b1;
    script.push_back(mk(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0));
    script.push_back(mk(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0));
    for (int i = 0; i < 12 && !rst_hit; i++) cycle();
    rst_on_hz = 1'b0;
    chk("mrst_hit", 32'(rst_hit), 32'd1);
    chk("mrst_valids", 32'({fs_valid, ds_valid, es_valid, ms_valid, ws_valid}), 32'd0);
    chk("mrst_stall", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    script.delete();
    run(7);

    // Hazard table against a full pipeline
    foreach (vecs[i]) begin
      logic exp;
`ifdef FORWARD_EN
      exp = vecs[i].exp_fwd;
`else
      exp = vecs[i].exp_nofwd;
`endif
      set_idle();
      id_rj = vecs[i].rj; id_rk = vecs[i].rk; id_use_rj = vecs[i].uj; id_use_rk = vecs[i].uk;
      ex_rd = vecs[i].ex_rd; ex_rf_we = vecs[i].ex_we; ex_is_load = vecs[i].ex_ld;
      mem_rd = vecs[i].mem_rd; mem_rf_we = vecs[i].mem_we;
      wb_rd = vecs[i].wb_rd; wb_rf_we = vecs[i].wb_we;
      #1;
      $display("vec %0d ds_ready_go=%0b pc_en=%0b", i, ds_ready_go, pc_en);
      chk("tbl_ds_ready_go", 32'(ds_ready_go), 32'(exp));
      chk("tbl_pc_en", 32'(pc_en), 32'(exp));
      #1;
      set_idle();
      @(negedge clk);
    end

    // Randomized run against the model
    rst = 1'b1; run(2);
    rst = 1'b0; rand_mode = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if_wait  = ($urandom_range(0, 4) == 0);
      ex_busy  = ($urandom_range(0, 4) == 0);
      mem_wait = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 96) == 0);
      cycle();
    end
    rst = 1'b0; if_wait = 1'b0; ex_busy = 1'b0; mem_wait = 1'b0; rand_mode = 1'b0;

    // Saturation of the stall counter
    rst = 1'b1; run(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      script.push_back(mk(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0));
      script.push_back(mk(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0));
    end
    run(120);
    chk("sat_stall", 32'(stall_cnt), 32'(SAT));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
